// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_mem_pkg
//  Purpose  : Shared types and helpers for the RV32 data-memory path:
//             bus widths, responder FSM state encoding and the byte-lane
//             write-mask builder.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Responder FSM encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Expand a byte-enable vector into a per-bit write mask:
    // be[i] covers data bits 8i+7:8i.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Request/response bus between the Mem stage (master) and the
//             data-memory responder (slave).
//  Signals  : req_valid/req_ready handshake, req_we, req_addr, req_wdata,
//             req_be (request side); resp_valid, resp_rdata, resp_err
//             (single-cycle response side, no back-pressure).
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import rv_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : DEPTH_WORDS x 32 single-port RAM, per-byte write enables,
//             synchronous write and registered read.
//  Ports    : clk     - clock
//             i_en    - access enable for this cycle
//             i_we    - 1 = write lanes selected by i_be, 0 = read
//             i_addr  - word index
//             i_be    - byte-lane enables for writes
//             i_wdata - write data
//             o_rdata - read data, updated on the edge after a read access
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  wire logic              clk,
    input  wire logic              i_en,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_addr,
    input  wire logic [BE_W-1:0]   i_be,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory target for the Mem stage. Accepts one request at a
//             time, waits LATENCY cycles, then issues a one-cycle response.
//             Misaligned or out-of-range accesses respond with resp_err and
//             leave the array untouched.
//  Ports    : clk - clock
//             rst - synchronous reset, active-high
//             bus - dmem_responder_if.slave (request handshake + response)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_responder_if.slave  bus
);

    localparam int                c_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int                c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH    = ADDR_W'(DEPTH_WORDS);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_commit;

    // Request fields as seen by the commit edge.
    logic                 w_src_we;
    logic [ADDR_W-1:0]    w_src_addr;
    logic [DATA_W-1:0]    w_src_wdata;
    logic [BE_W-1:0]      w_src_be;
    logic                 w_src_err;

    logic                 r_resp_valid;
    logic                 r_resp_err;
    logic                 r_rdata_ok;
    logic [DATA_W-1:0]    w_arr_rdata;
    logic                 w_arr_en;

    assign w_ready  = !rst && ((r_state == IDLE) || (r_state == RESP));
    assign w_accept = bus.req_valid && w_ready;

    // With LATENCY==1 the commit edge is the accept edge, so the array must
    // see the live request; otherwise it sees the fields latched at accept,
    // which also makes input changes during WAIT irrelevant.
    generate
        if (LATENCY == 1) begin : g_live_src
            assign w_src_we    = bus.req_we;
            assign w_src_addr  = bus.req_addr;
            assign w_src_wdata = bus.req_wdata;
            assign w_src_be    = bus.req_be;
        end else begin : g_latched_src
            logic              r_we;
            logic [ADDR_W-1:0] r_addr;
            logic [DATA_W-1:0] r_wdata;
            logic [BE_W-1:0]   r_be;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_we    <= bus.req_we;
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    r_be    <= bus.req_be;
                end
            end

            assign w_src_we    = r_we;
            assign w_src_addr  = r_addr;
            assign w_src_wdata = r_wdata;
            assign w_src_be    = r_be;
        end
    endgenerate

    // Full 30-bit word-index compare: high address bits never alias.
    assign w_src_err = (w_src_addr[1:0] != 2'b00) ||
                       ({2'b00, w_src_addr[ADDR_W-1:2]} >= c_DEPTH);

    // Next-state / counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_state_next = (LATENCY == 1) ? RESP : WAIT;
                    w_cnt_next   = c_CNT_LOAD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Every entry into RESP is a commit; a reset in that cycle cancels it.
    assign w_commit = !rst && (w_state_next == RESP);
    assign w_arr_en = w_commit && !w_src_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata_ok   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_resp_valid <= w_commit;
            r_resp_err   <= w_commit && w_src_err;
            r_rdata_ok   <= w_commit && !w_src_we && !w_src_err;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (w_src_we),
        .i_addr  (w_src_addr[c_AW+1:2]),
        .i_be    (w_src_be),
        .i_wdata (w_src_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The RAM read register is not reset, so load data is gated by a
    // registered qualifier: zero for stores, errors and outside RESP.
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_rdata_ok ? w_arr_rdata : '0;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the five-stage RV32 pipeline; it is the target of the load/store requests issued by the Mem stage.
- Accepts one request at a time over a valid/ready handshake and models a configurable multi-cycle access latency.
- Returns exactly one response pulse per accepted request.
- The Mem stage derives its stall signal from this handshake (request outstanding and no response yet). That logic is outside this block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; legal word index is 0..DEPTH_WORDS-1
LATENCY, 2, cycles from the accept edge to resp_valid high; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i); ignored for loads
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  misaligned or out-of-range access; valid with resp_valid

Behaviour:
- Synchronous reset, active-high; clk is the only clock.
- FSM states: IDLE, WAIT, RESP.
- req_ready = !rst && (state==IDLE || state==RESP).
- Accept occurs when req_valid && req_ready. On the accept edge, latch we, addr, wdata and be, and load the counter with LATENCY-1.
- Transitions on the accept edge:
  - LATENCY==1: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter==1, go to RESP.
- Commit edge (the edge that enters RESP):
  - Stores are written to the array, byte lanes per be.
  - Loads are read from the array (synchronous read), so resp_rdata is valid in the RESP cycle.
  - resp_valid and resp_err are registered on this same edge.
- RESP lasts exactly one cycle, with resp_valid=1. There is no back-pressure on the response.
- Leaving RESP:
  - If a new request is accepted in the RESP cycle, go to WAIT (or back to RESP when LATENCY==1).
  - Otherwise go to IDLE.
- Timing: resp_valid rises exactly LATENCY cycles after the accept edge. Back-to-back throughput is one request per LATENCY cycles.
- Error conditions: addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS.
  - On error: resp_err=1, resp_rdata=0, and no array write.
  - Range compare uses the full 30-bit word index; no aliasing or wrap-around.
- Store with be==4'b0000: no array change, resp_err=0, response still issued.
- Store response: resp_rdata=0, resp_err=0 (unless an error condition applies).
- Loads return the full word; sign/zero extension and lane select are done by the Mem stage.
- Inputs are sampled only on the accept edge; changes while in WAIT are ignored.
- Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 while rst is high and 1 in the first cycle after.
- Array contents are not reset.
- Reset mid-operation (in WAIT or RESP): the pending request is dropped. If reset hits before the commit edge, the store is not committed and no response is issued. A response already in RESP is cleared on the reset edge.

Decomposition:
- Shared package rv_mem_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP, 2 bits)
  - BE_W=4, DATA_W=32, ADDR_W=32
  - the byte-lane mask function used to build a 32-bit write mask from be
- One sub-module, dmem_array: DEPTH_WORDS x 32 single-port RAM with per-byte write enables, synchronous write, and registered read.
- The responder holds the FSM, counter, request latches, error decode and response registers.

Test Plan:
1. Reset: hold rst 3 cycles with req_valid=1 → req_ready=0 and resp_valid=0 throughout; req_ready=1 on the first cycle after release.
2. LATENCY=2: store 0xDEADBEEF to 0x10, be=4'hF, accepted at cycle t → resp_valid=1 only at t+2 with resp_err=0. Then load 0x10 → resp_rdata=0xDEADBEEF exactly 2 cycles after its accept.
3. Partial store to 0x10: be=4'b0010, wdata=0x0000AA00 → subsequent load returns 0xDEADAAEF. A store with be=0 leaves 0xDEADAAEF unchanged.
4. Errors:
   - Load 0x13 → resp_err=1, resp_rdata=0.
   - Store 0x00001000 with DEPTH_WORDS=1024 → resp_err=1; word 0 is unaltered (no alias).
5. Back-to-back: keep req_valid high during the RESP cycle with a new load → accepted that cycle; next resp_valid LATENCY cycles later. Repeat with LATENCY=1 → resp_valid high on consecutive cycles.
6. Reset mid-operation: with LATENCY=4, assert rst for one cycle while in WAIT of a store of 0x12345678 to 0x20 → no resp_valid for that store, and a later load of 0x20 returns the prior contents.
